// File: rtl/alu_exec_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_pkg                                                     |
// | Brief   : Opcodes, ALU selects and FSM state type for alu_exec_ctrl.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_exec_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_CMP  = 3'b101;
   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_SUB = 3'b001;
   localparam logic [2:0] SEL_AND = 3'b010;
   localparam logic [2:0] SEL_OR  = 3'b011;
   localparam logic [2:0] SEL_XOR = 3'b100;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   // CMP reuses the subtractor; MOV is OR with a zero A operand.
   function automatic logic [2:0] op_to_sel(input logic [2:0] op);
      case (op)
         OP_ADD:  op_to_sel = SEL_ADD;
         OP_SUB:  op_to_sel = SEL_SUB;
         OP_AND:  op_to_sel = SEL_AND;
         OP_OR:   op_to_sel = SEL_OR;
         OP_XOR:  op_to_sel = SEL_XOR;
         OP_CMP:  op_to_sel = SEL_SUB;
         OP_MOV:  op_to_sel = SEL_OR;
         default: op_to_sel = SEL_ADD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_exec_regfile.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_regfile                                                 |
// | Brief   : 2R/1W register file; ALU_EXEC_DBG_PORT_EN adds a debug read.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_regfile #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_we,
   input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr_a,
   output logic [DATA_W-1:0]           o_rdata_a,
   input  logic [$clog2(NUM_REGS)-1:0] i_raddr_b,
   output logic [DATA_W-1:0]           o_rdata_b
`ifdef ALU_EXEC_DBG_PORT_EN
   ,
   input  logic [$clog2(NUM_REGS)-1:0] i_dbg_addr,
   output logic [DATA_W-1:0]           o_dbg_data
`endif
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

`ifdef ALU_EXEC_DBG_PORT_EN
   assign o_dbg_data = r_mem[i_dbg_addr];
`endif

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : alu_exec_ctrl                                                    |
// | Brief   : Two-cycle execute controller driving a combinational 8-bit ALU.  |
// |           ALU_EXEC_DBG_PORT_EN adds DbgAddr/DbgData register peek ports.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        InstrValid,
   output logic                        InstrReady,
   input  logic [2:0]                  InstrOp,
   input  logic [$clog2(NUM_REGS)-1:0] InstrRd,
   input  logic [$clog2(NUM_REGS)-1:0] InstrRs,
   input  logic                        InstrImmEn,
   input  logic [DATA_W-1:0]           InstrImm,
   output logic [DATA_W-1:0]           AluA,
   output logic [DATA_W-1:0]           AluB,
   output logic [2:0]                  AluSel,
   input  logic [DATA_W-1:0]           AluOut,
   input  logic                        AluCarry,
   output logic                        DoneValid,
   output logic [DATA_W-1:0]           DoneData,
   output logic                        ZeroFlag,
   output logic                        CarryFlag,
   output logic                        IllegalOp
`ifdef ALU_EXEC_DBG_PORT_EN
   ,
   input  logic [$clog2(NUM_REGS)-1:0] DbgAddr,
   output logic [DATA_W-1:0]           DbgData
`endif
);

   localparam int c_AW = $clog2(NUM_REGS);

   state_t            r_state;
   state_t            w_next_state;
   logic [2:0]        r_op;
   logic [c_AW-1:0]   r_rd;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [2:0]        r_alu_sel;
   logic              r_done_valid;
   logic [DATA_W-1:0] r_done_data;
   logic              r_zero;
   logic              r_carry;
   logic              r_illegal;

   logic              w_accept;
   logic              w_legal;
   logic              w_we;
   logic              w_arith;
   logic [DATA_W-1:0] w_rdata_a;
   logic [DATA_W-1:0] w_rdata_b;

   assign w_legal = (InstrOp != OP_RSVD);
   assign w_we    = (r_state == ST_EXEC) && (r_op != OP_CMP);
   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_CMP);

   alu_exec_regfile #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we),
      .i_waddr   (r_rd),
      .i_wdata   (AluOut),
      .i_raddr_a (InstrRd),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (InstrRs),
      .o_rdata_b (w_rdata_b)
`ifdef ALU_EXEC_DBG_PORT_EN
      ,
      .i_dbg_addr (DbgAddr),
      .o_dbg_data (DbgData)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      InstrReady   = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            InstrReady = 1'b1;
            w_accept   = InstrValid;
            if (InstrValid && w_legal) begin
               w_next_state = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op         <= OP_ADD;
         r_rd         <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= SEL_ADD;
         r_done_valid <= 1'b0;
         r_done_data  <= '0;
         r_zero       <= 1'b0;
         r_carry      <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_done_valid <= 1'b0;
         r_illegal    <= 1'b0;
         if (w_accept) begin
            if (w_legal) begin
               r_op      <= InstrOp;
               r_rd      <= InstrRd;
               r_alu_a   <= (InstrOp == OP_MOV) ? '0 : w_rdata_a;
               r_alu_b   <= InstrImmEn ? InstrImm : w_rdata_b;
               r_alu_sel <= op_to_sel(InstrOp);
            end else begin
               r_illegal <= 1'b1;
            end
         end
         if (r_state == ST_EXEC) begin
            r_done_valid <= 1'b1;
            r_done_data  <= AluOut;
            r_zero       <= (AluOut == '0);
            // Logic ops leave AluCarry undriven, so it is masked, not sampled.
            r_carry      <= w_arith ? AluCarry : 1'b0;
         end
      end
   end

   assign AluA      = r_alu_a;
   assign AluB      = r_alu_b;
   assign AluSel    = r_alu_sel;
   assign DoneValid = r_done_valid;
   assign DoneData  = r_done_data;
   assign ZeroFlag  = r_zero;
   assign CarryFlag = r_carry;
   assign IllegalOp = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_exec_ctrl                                                 |
// | Brief   : Self-checking bench with behavioural ALU and reference model.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_exec_ctrl;

   logic       clk;
   logic       rst_n;
   logic       InstrValid;
   logic       InstrReady;
   logic [2:0] InstrOp;
   logic [1:0] InstrRd;
   logic [1:0] InstrRs;
   logic       InstrImmEn;
   logic [7:0] InstrImm;
   logic [7:0] AluA;
   logic [7:0] AluB;
   logic [2:0] AluSel;
   logic [7:0] AluOut;
   logic       AluCarry;
   logic       DoneValid;
   logic [7:0] DoneData;
   logic       ZeroFlag;
   logic       CarryFlag;
   logic       IllegalOp;
`ifdef ALU_EXEC_DBG_PORT_EN
   logic [1:0] DbgAddr;
   logic [7:0] DbgData;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_reg [4];
   logic       m_zero;
   logic       m_carry;

   alu_exec_ctrl #(.NUM_REGS(4), .DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .InstrOp    (InstrOp),
      .InstrRd    (InstrRd),
      .InstrRs    (InstrRs),
      .InstrImmEn (InstrImmEn),
      .InstrImm   (InstrImm),
      .AluA       (AluA),
      .AluB       (AluB),
      .AluSel     (AluSel),
      .AluOut     (AluOut),
      .AluCarry   (AluCarry),
      .DoneValid  (DoneValid),
      .DoneData   (DoneData),
      .ZeroFlag   (ZeroFlag),
      .CarryFlag  (CarryFlag),
      .IllegalOp  (IllegalOp)
`ifdef ALU_EXEC_DBG_PORT_EN
      ,
      .DbgAddr    (DbgAddr),
      .DbgData    (DbgData)
`endif
   );

`ifdef ALU_EXEC_DBG_PORT_EN
   assign DbgAddr = 2'd0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: carry is deliberately unknown for the logic operations.
   always_comb begin
      AluOut   = 8'h00;
      AluCarry = 1'bx;
      case (AluSel)
         3'b000: {AluCarry, AluOut} = {1'b0, AluA} + {1'b0, AluB};
         3'b001: begin AluOut = AluA - AluB; AluCarry = (AluA < AluB); end
         3'b010: AluOut = AluA & AluB;
         3'b011: AluOut = AluA | AluB;
         3'b100: AluOut = AluA ^ AluB;
         default: AluOut = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_sel(input logic [2:0] op);
      case (op)
         3'd0: return 3'd0;
         3'd1: return 3'd1;
         3'd2: return 3'd2;
         3'd3: return 3'd3;
         3'd4: return 3'd4;
         3'd5: return 3'd1;
         default: return 3'd3;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_zero  = 1'b0;
      m_carry = 1'b0;
   endtask

   // Entered and left on a falling edge.
   task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic ie, input logic [7:0] imm, input bit hold);
      logic [7:0] a, b, res;
      logic [8:0] sum;
      logic       c;
      int         t;
      t = 0;
      while (InstrReady !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", InstrReady, 1);
      InstrValid = 1'b1; InstrOp = op; InstrRd = rd; InstrRs = rs;
      InstrImmEn = ie; InstrImm = imm;
      @(negedge clk);
      if (op == 3'b111) begin
         InstrValid = 1'b0;
         check("illegal_pulse", IllegalOp, 1);
         check("illegal_nodone", DoneValid, 0);
         check("illegal_ready", InstrReady, 1);
         @(negedge clk);
         check("illegal_once", IllegalOp, 0);
         check("illegal_zero", ZeroFlag, m_zero);
         check("illegal_carry", CarryFlag, m_carry);
         return;
      end
      a = (op == 3'b110) ? 8'h00 : m_reg[rd];
      b = ie ? imm : m_reg[rs];
      c = 1'b0;
      case (op)
         3'd0: begin sum = a + b; res = sum[7:0]; c = sum[8]; end
         3'd1, 3'd5: begin res = a - b; c = (a < b); end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         default: res = b;
      endcase
      check("exec_ready", InstrReady, 0);
      check("exec_nodone", DoneValid, 0);
      check("alu_a", AluA, a);
      check("alu_b", AluB, b);
      check("alu_sel", AluSel, exp_sel(op));
      if (!hold) InstrValid = 1'b0;
      @(negedge clk);
      InstrValid = 1'b0;
      if (op != 3'd5) m_reg[rd] = res;
      m_zero  = (res == 8'h00);
      m_carry = c;
      check("done_valid", DoneValid, 1);
      check("done_data", DoneData, res);
      check("zero_flag", ZeroFlag, m_zero);
      check("carry_flag", CarryFlag, m_carry);
      check("ready_back", InstrReady, 1);
      if (hold) begin
         @(negedge clk);
         check("no_double", DoneValid, 0);
      end
   endtask

   task automatic read_reg(input logic [1:0] r, input logic [7:0] exp);
      issue(3'd3, r, 2'd0, 1'b1, 8'h00, 1'b0);
      check("reg_value", m_reg[r], exp);
   endtask

   initial begin
      InstrValid = 1'b0; InstrOp = 3'd0; InstrRd = 2'd0; InstrRs = 2'd0;
      InstrImmEn = 1'b0; InstrImm = 8'h00;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_done", DoneValid, 0);
      check("rst_data", DoneData, 0);
      check("rst_zero", ZeroFlag, 0);
      check("rst_carry", CarryFlag, 0);
      check("rst_sel", AluSel, 0);
      check("rst_illegal", IllegalOp, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", InstrReady, 1);

      issue(3'd6, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0);
      issue(3'd6, 2'd1, 2'd0, 1'b1, 8'h0A, 1'b0);
      issue(3'd6, 2'd0, 2'd0, 1'b1, 8'hF0, 1'b0);
      issue(3'd0, 2'd0, 2'd0, 1'b1, 8'h20, 1'b0);
      check("add_wrap", DoneData, 8'h10);
      issue(3'd0, 2'd0, 2'd0, 1'b1, 8'hF0, 1'b0);
      check("add_zero", ZeroFlag, 1);
      issue(3'd6, 2'd1, 2'd0, 1'b1, 8'h03, 1'b0);
      issue(3'd1, 2'd1, 2'd0, 1'b1, 8'h05, 1'b0);
      check("sub_borrow", CarryFlag, 1);
      issue(3'd5, 2'd1, 2'd0, 1'b1, 8'hFE, 1'b0);
      read_reg(2'd1, 8'hFE);
      issue(3'd6, 2'd0, 2'd0, 1'b1, 8'h5A, 1'b0);
      issue(3'd4, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1);
      check("xor_self", DoneData, 8'h00);
      issue(3'd6, 2'd3, 2'd0, 1'b1, 8'h81, 1'b0);
      issue(3'd7, 2'd3, 2'd3, 1'b1, 8'hFF, 1'b0);
      read_reg(2'd3, 8'h81);

      // Abort ADD R2,#1 by resetting in its EXEC cycle.
      InstrValid = 1'b1; InstrOp = 3'd0; InstrRd = 2'd2; InstrRs = 2'd0;
      InstrImmEn = 1'b1; InstrImm = 8'h01;
      @(negedge clk);
      InstrValid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("abort_ready", InstrReady, 1);
      @(negedge clk);
      check("abort_done", DoneValid, 0);
      check("abort_a", AluA, 0);
      check("abort_b", AluB, 0);
      check("abort_sel", AluSel, 0);
      check("abort_zero", ZeroFlag, 0);
      check("abort_carry", CarryFlag, 0);
      check("abort_data", DoneData, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready_rel", InstrReady, 1);
      read_reg(2'd2, 8'h00);

      for (int n = 0; n < 300; n++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         issue(op, 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), bit'($urandom));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      for (int r = 0; r < 4; r++) read_reg(2'(r), m_reg[r]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
